scan_mux_latch_array: RTL and testbench
=======================================

Name: scan_mux_latch_array

Overview:
- Parametrised time-division scanner.
- A free-running channel counter selects one of NUM_CH single-bit inputs per dwell window, drives the selected bit as serial data, and routes it through a decoder into per-channel capture flags.
- Replaces the fixed 4-channel counter/mux/decoder/latch chain.
- Adds: configurable channel count and dwell, a channel mask, sticky or tracking capture mode, software clear, frame pulse and per-frame hit count.
- Sits between VIO-driven inputs and ILA-probed outputs.
- Fully synchronous; no latches are inferred.

Parameters:
- NUM_CH, 4: number of scanned channels, 2..64.
- SEL_W, $clog2(NUM_CH): width of channel select.
- DWELL, 1: clock cycles spent on each channel, 1..256.
- STICKY, 1: 1 = capture flags set-only until cleared; 0 = flags track the last sample of each channel.
- CNT_W, $clog2(NUM_CH+1): width of hit_count.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- en  input  1  scan enable; low freezes scanning
- clr  input  1  synchronous clear of all capture flags
- din  input  NUM_CH  channel inputs; bit i = channel i
- ch_mask  input  NUM_CH  1 = channel i may set/update its flag
- sel  output  SEL_W  channel currently being scanned
- data_out  output  1  registered sample of the last sampled channel
- sample_valid  output  1  one-cycle pulse, data_out/sample_ch updated this cycle
- sample_ch  output  SEL_W  channel index of data_out
- flags  output  NUM_CH  capture flags (decoded, latched)
- frame_done  output  1  one-cycle pulse after channel NUM_CH-1 sampled
- hit_count  output  CNT_W  number of channels sampled high in last completed frame (unmasked only)

Behaviour:
- Reset (rst_n=0 at clk edge): sel=0, internal dwell_cnt=0, data_out=0, sample_valid=0, sample_ch=0, flags=0, frame_done=0, hit_count=0, internal frame accumulator=0. Reset takes priority over every other input.
- Dwell counter:
  - With en=1, dwell_cnt counts 0..DWELL-1 and then wraps to 0.
  - The sample cycle is any en=1 cycle with dwell_cnt==DWELL-1.
  - With DWELL=1, every en=1 cycle is a sample cycle.
- Channel counter: on a sample cycle, sel increments; from NUM_CH-1 it wraps to 0, so non-power-of-2 NUM_CH never visits indices >= NUM_CH.
- Sample path (latency 1):
  - On a sample cycle, data_out <= din[sel], sample_ch <= sel, sample_valid <= 1.
  - On all other cycles sample_valid <= 0 and data_out/sample_ch hold.
- Decoder/capture, evaluated on the sample cycle for channel s=sel, only if ch_mask[s]=1:
  - STICKY=1: din[s]=1 sets flags[s]; din[s]=0 leaves it unchanged.
  - STICKY=0: flags[s] <= din[s].
  - A masked channel's flag holds its value.
  - Flags update in the same edge as data_out (latency 1).
- clr:
  - clr=1 zeroes all flags at the next edge, regardless of en.
  - Simultaneous clr and a sample-cycle set of channel s: flags[s] ends at 1 (new hit not lost) and all other flags end at 0.
  - clr does not affect sel, the dwell counter, hit_count or the accumulator.
- Frame accounting:
  - The accumulator adds 1 for each sample cycle with din[sel]=1 and ch_mask[sel]=1.
  - On the sample cycle of channel NUM_CH-1, at the next edge: hit_count <= accumulator plus the current contribution, frame_done <= 1, and the accumulator <= 0.
  - frame_done is coincident with the sample_valid for channel NUM_CH-1.
- en=0: dwell_cnt, sel and the accumulator hold; no sample cycle occurs; sample_valid=0 and frame_done=0; flags hold except for clr. Scanning resumes from the held position when en returns to 1.
- Reset mid-frame: the partial frame is discarded and the next frame starts at channel 0 with a zero accumulator.
- ch_mask and din changes take effect at the next sample cycle only; no combinational path from din to any output.

Test Plan:
1. NUM_CH=4, DWELL=1, STICKY=1, mask=4'hF, din=4'b0101, 8 cycles after reset release:
   - sel sequence 0,1,2,3,0,...
   - data_out 1,0,1,0 one cycle behind sel.
   - flags=4'b0101.
   - frame_done pulses every 4 cycles with hit_count=2.
2. NUM_CH=5, DWELL=3:
   - sel holds 3 cycles per channel and wraps 4->0 (never 5..7).
   - sample_valid pulses every 3rd cycle.
   - frame_done pulses every 15 cycles.
3. STICKY=0, mask=all-ones, din=4'b1111 for one frame then 4'b0000:
   - flags go to 4'hF, then clear bit-by-bit in scan order 0,1,2,3.
   - hit_count goes 4 then 0.
4. STICKY=1, mask=4'b1011, din=4'hF, one frame:
   - flags=4'b1011, hit_count=3.
   - Assert clr on the sample cycle of channel 1: flags=4'b0010 next cycle.
5. en=0 for 10 cycles mid-frame at sel=2:
   - sel stays 2; no sample_valid or frame_done.
   - After en=1, scan continues 2,3 and frame_done reports the full-frame count.
6. rst_n=0 for one cycle mid-frame (sel=3, flags nonzero):
   - All outputs zero next cycle.
   - The next frame_done comes NUM_CH*DWELL sample-enabled cycles later.

Source files
------------

// File: rtl/scan_mux_latch_array.sv
// Time-division scanner: a dwell-paced channel counter picks one din bit per window,
// registers it as serial data and folds it into per-channel capture flags and a per-frame hit count.
module scan_mux_latch_array #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int DWELL  = 1,
  parameter bit STICKY = 1'b1,
  parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel,
  output logic              data_out,
  output logic              sample_valid,
  output logic [SEL_W-1:0]  sample_ch,
  output logic [NUM_CH-1:0] flags,
  output logic              frame_done,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_CH - 1);

  logic [DW-1:0]     dwell_q, dwell_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              data_q, data_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  sample_ch_q, sample_ch_d;
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic              frame_q, frame_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  acc_q, acc_d;

  logic sample, last_ch, cur_bit, cur_mask, hit;

  always_comb begin
    sample   = en && (dwell_q == DWELL_LAST);
    last_ch  = (sel_q == SEL_LAST);
    cur_bit  = din[sel_q];
    cur_mask = ch_mask[sel_q];
    hit      = cur_bit & cur_mask;

    dwell_d     = dwell_q;
    sel_d       = sel_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sample_ch_d = sample_ch_q;
    flags_d     = flags_q;
    frame_d     = 1'b0;
    hit_d       = hit_q;
    acc_d       = acc_q;

    if (en) begin
      dwell_d = sample ? '0 : dwell_q + 1'b1;
    end

    // Clear first so a hit landing on the same edge survives the clear.
    if (clr) begin
      flags_d = '0;
    end

    if (sample) begin
      sel_d       = last_ch ? '0 : sel_q + 1'b1;
      data_d      = cur_bit;
      sample_ch_d = sel_q;
      valid_d     = 1'b1;

      if (cur_mask) begin
        if (STICKY) begin
          if (cur_bit) begin
            flags_d[sel_q] = 1'b1;
          end
        end else begin
          flags_d[sel_q] = cur_bit;
        end
      end

      // The last channel's own contribution goes straight into the published count.
      if (last_ch) begin
        hit_d   = acc_q + CNT_W'(hit);
        acc_d   = '0;
        frame_d = 1'b1;
      end else begin
        acc_d = acc_q + CNT_W'(hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      sel_q       <= '0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      sample_ch_q <= '0;
      flags_q     <= '0;
      frame_q     <= 1'b0;
      hit_q       <= '0;
      acc_q       <= '0;
    end else begin
      dwell_q     <= dwell_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sample_ch_q <= sample_ch_d;
      flags_q     <= flags_d;
      frame_q     <= frame_d;
      hit_q       <= hit_d;
      acc_q       <= acc_d;
    end
  end

  assign sel          = sel_q;
  assign data_out     = data_q;
  assign sample_valid = valid_q;
  assign sample_ch    = sample_ch_q;
  assign flags        = flags_q;
  assign frame_done   = frame_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_scan_mux_latch_array.sv
// Directed bench for scan_mux_latch_array: three instances cover the 4ch/dwell-1 sticky,
// 5ch/dwell-3 and 4ch tracking configurations.
module tb_scan_mux_latch_array;

  logic clk;
  int   checkCount;
  int   passCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_CH=4, DWELL=1, STICKY=1
  logic       aRstN, aEn, aClr;
  logic [3:0] aDin, aMask;
  logic [1:0] aSel, aSampleCh;
  logic       aData, aValid, aFrame;
  logic [3:0] aFlags;
  logic [2:0] aHit;

  scan_mux_latch_array #(.NUM_CH(4), .DWELL(1), .STICKY(1'b1)) dutA (
    .clk(clk), .rst_n(aRstN), .en(aEn), .clr(aClr), .din(aDin), .ch_mask(aMask),
    .sel(aSel), .data_out(aData), .sample_valid(aValid), .sample_ch(aSampleCh),
    .flags(aFlags), .frame_done(aFrame), .hit_count(aHit)
  );

  // Instance B: NUM_CH=5, DWELL=3, STICKY=1
  logic       bRstN, bEn, bClr;
  logic [4:0] bDin, bMask;
  logic [2:0] bSel, bSampleCh;
  logic       bData, bValid, bFrame;
  logic [4:0] bFlags;
  logic [2:0] bHit;

  scan_mux_latch_array #(.NUM_CH(5), .DWELL(3), .STICKY(1'b1)) dutB (
    .clk(clk), .rst_n(bRstN), .en(bEn), .clr(bClr), .din(bDin), .ch_mask(bMask),
    .sel(bSel), .data_out(bData), .sample_valid(bValid), .sample_ch(bSampleCh),
    .flags(bFlags), .frame_done(bFrame), .hit_count(bHit)
  );

  // Instance C: NUM_CH=4, DWELL=1, STICKY=0
  logic       cRstN, cEn, cClr;
  logic [3:0] cDin, cMask;
  logic [1:0] cSel, cSampleCh;
  logic       cData, cValid, cFrame;
  logic [3:0] cFlags;
  logic [2:0] cHit;

  scan_mux_latch_array #(.NUM_CH(4), .DWELL(1), .STICKY(1'b0)) dutC (
    .clk(clk), .rst_n(cRstN), .en(cEn), .clr(cClr), .din(cDin), .ch_mask(cMask),
    .sel(cSel), .data_out(cData), .sample_valid(cValid), .sample_ch(cSampleCh),
    .flags(cFlags), .frame_done(cFrame), .hit_count(cHit)
  );

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstN, input logic en, input logic clr,
                               input logic [3:0] din, input logic [3:0] mask);
    aRstN = rstN;
    aEn   = en;
    aClr  = clr;
    aDin  = din;
    aMask = mask;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  logic [3:0] patA;
  logic [4:0] patB;

  initial begin
    checkCount = 0;
    passCount  = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101, 4'hF);
    bRstN = 1'b0; bEn = 1'b1; bClr = 1'b0; bDin = 5'b10110; bMask = 5'b11111;
    cRstN = 1'b0; cEn = 1'b1; cClr = 1'b0; cDin = 4'hF;     cMask = 4'hF;

    // Test 1: reset state, then 8 cycles of 4ch/dwell-1 sticky scanning
    tick();
    checkOutput("rst sel",   aSel,      0);
    checkOutput("rst data",  aData,     0);
    checkOutput("rst valid", aValid,    0);
    checkOutput("rst sch",   aSampleCh, 0);
    checkOutput("rst flags", aFlags,    0);
    checkOutput("rst frame", aFrame,    0);
    checkOutput("rst hit",   aHit,      0);
    patA  = 4'b0101;
    aRstN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("t1 sel",   aSel,      64'(i % 4));
      checkOutput("t1 data",  aData,     64'(patA[(i - 1) % 4]));
      checkOutput("t1 sch",   aSampleCh, 64'((i - 1) % 4));
      checkOutput("t1 valid", aValid,    1);
      checkOutput("t1 frame", aFrame,    64'(i % 4 == 0));
    end
    checkOutput("t1 flags", aFlags, 4'b0101);
    checkOutput("t1 hit",   aHit,   2);

    // Test 2: 5 channels, dwell 3
    bRstN = 1'b1;
    patB  = 5'b10110;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checkOutput("t2 sel",   bSel,   64'((i / 3) % 5));
      checkOutput("t2 valid", bValid, 64'(i % 3 == 0));
      checkOutput("t2 frame", bFrame, 64'(i % 15 == 0));
      if (i % 3 == 0) begin
        checkOutput("t2 sch",  bSampleCh, 64'(((i / 3) - 1) % 5));
        checkOutput("t2 data", bData,     64'(patB[((i / 3) - 1) % 5]));
      end
      if (i % 15 == 0) checkOutput("t2 hit", bHit, 3);
    end
    bRstN = 1'b0;

    // Test 3: tracking mode, all ones for a frame, then all zeros
    cRstN = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkOutput("t3 flags up", cFlags, 64'((1 << j) - 1));
    end
    checkOutput("t3 frame1", cFrame, 1);
    checkOutput("t3 hit4",   cHit,   4);
    cDin = 4'h0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkOutput("t3 flags down", cFlags, 64'(15 & ~((1 << j) - 1)));
    end
    checkOutput("t3 frame2", cFrame, 1);
    checkOutput("t3 hit0",   cHit,   0);
    cRstN = 1'b0;

    // Test 4: masked channel 2, then clear coinciding with the channel-1 hit
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'b1011);
    tick();
    aRstN = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    checkOutput("t4 frame", aFrame, 1);
    checkOutput("t4 flags", aFlags, 4'b1011);
    checkOutput("t4 hit",   aHit,   3);
    tick();
    aClr = 1'b1;
    tick();
    aClr = 1'b0;
    checkOutput("t4 clr flags", aFlags, 4'b0010);
    checkOutput("t4 clr sel",   aSel,   2);

    // Test 5: pause at sel=2 for 10 cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1011, 4'hF);
    tick();
    aRstN = 1'b1;
    tick();
    tick();
    checkOutput("t5 sel pre", aSel, 2);
    aEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t5 hold sel",   aSel,   2);
      checkOutput("t5 hold valid", aValid, 0);
      checkOutput("t5 hold frame", aFrame, 0);
    end
    aEn = 1'b1;
    tick();
    checkOutput("t5 resume sel",   aSel,   3);
    checkOutput("t5 resume valid", aValid, 1);
    checkOutput("t5 resume frame", aFrame, 0);
    tick();
    checkOutput("t5 end sel",   aSel,   0);
    checkOutput("t5 end frame", aFrame, 1);
    checkOutput("t5 end hit",   aHit,   3);

    // Test 6: reset mid-frame discards the partial frame
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
    tick();
    aRstN = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t6 pre sel",   aSel,   3);
    checkOutput("t6 pre flags", aFlags, 4'b0111);
    aRstN = 1'b0;
    tick();
    aRstN = 1'b1;
    checkOutput("t6 rst sel",   aSel,      0);
    checkOutput("t6 rst data",  aData,     0);
    checkOutput("t6 rst valid", aValid,    0);
    checkOutput("t6 rst sch",   aSampleCh, 0);
    checkOutput("t6 rst flags", aFlags,    0);
    checkOutput("t6 rst frame", aFrame,    0);
    checkOutput("t6 rst hit",   aHit,      0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("t6 frame", aFrame, 64'(k == 4));
    end
    checkOutput("t6 hit", aHit, 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
